// File: rtl/fetch_const_assembler_pkg.sv
// Shared definitions for the fetch-stage displacement/immediate assembler:
// controller state encoding, default queue depth and the field-size type.
package fetch_pkg;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_DISP = 2'd1,
    C_IMM  = 2'd2,
    C_OUT  = 2'd3
  } cstate_t;

  localparam int MQ_N_DEF      = 4;
  localparam int MAX_BYTES_DEF = 8;

  // Byte-count type for the default build (0..MAX_BYTES_DEF).
  typedef logic [$clog2(MAX_BYTES_DEF+1)-1:0] const_size_t;

endpackage

// File: rtl/fetch_const_assembler_merge.sv
// const_byte_merge: drops one little-endian byte into lane idx of an
// accumulator. Lanes below idx are kept, and every bit above the new
// lane becomes the fill bit: byte[7] for sign extension, 0 for zero
// extension.
module const_byte_merge #(
  parameter int OUT_W = 64,
  parameter int IDX_W = 4
) (
  input  logic [OUT_W-1:0] acc,
  input  logic [7:0]       byte_in,
  input  logic [IDX_W-1:0] idx,
  input  logic             zext,
  output logic [OUT_W-1:0] merged
);

  logic             fill;
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] keep_mask;

  // Lower lanes come from the old accumulator; the new byte and the fill
  // bits above it come from the extended byte shifted into place.
  always_comb begin
    fill      = byte_in[7] & ~zext;
    ext       = {{(OUT_W-8){fill}}, byte_in};
    keep_mask = ~({OUT_W{1'b1}} << {idx, 3'b000});
    merged    = (acc & keep_mask) | ((ext << {idx, 3'b000}) & ~keep_mask);
  end

endmodule

// File: rtl/fetch_const_assembler.sv
// fetch_const_assembler: collects the displacement and then the immediate
// of one x86-64 instruction from the fetch byte stream, one byte per cycle,
// and offers both constants plus the destination slot mask to the queue
// writer until it accepts them.
//
// Handshakes: a transfer happens on any rising clk edge where valid and
// ready are both high (start/start_ready, byte_valid/byte_ready,
// out_valid/out_ready). Ready and out_valid are decoded from the state
// register only, so no input reaches an output combinationally. flush wins
// over every handshake in the same cycle.
//
// Build option FETCH_CONST_ZEXT_EN adds a zext input; when latched high at
// start, both fields are zero-extended instead of sign-extended.
module fetch_const_assembler
  import fetch_pkg::*;
#(
  parameter int MAX_BYTES = 8,
  parameter int OUT_W     = 64,
  parameter int MQ_N      = MQ_N_DEF,
  parameter int SZ_W      = $clog2(MAX_BYTES+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             start_ready,
  input  logic [SZ_W-1:0]  disp_size,
  input  logic [SZ_W-1:0]  imm_size,
  input  logic [MQ_N-1:0]  to_mask,
`ifdef FETCH_CONST_ZEXT_EN
  input  logic             zext,
`endif
  input  logic             flush,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_disp,
  output logic [OUT_W-1:0] out_imm,
  output logic [MQ_N-1:0]  out_to,
  output logic             busy
);

  cstate_t          state, state_next;
  logic [SZ_W-1:0]  disp_sz_q, imm_sz_q, cnt, cnt_inc, cur_size;
  logic [SZ_W-1:0]  disp_sz_in, imm_sz_in;
  logic [OUT_W-1:0] disp_acc, imm_acc, merge_acc, merged;
  logic [MQ_N-1:0]  to_q;
  logic             in_field, last_byte;

`ifdef FETCH_CONST_ZEXT_EN
  logic             zext_q;
`else
  logic             zext_q;
  assign zext_q = 1'b0;
`endif

  // Oversized requests are clamped so the counter can never run past the
  // widest field.
  function automatic logic [SZ_W-1:0] clamp_size(input logic [SZ_W-1:0] s);
    if (int'(s) > MAX_BYTES) return SZ_W'(MAX_BYTES);
    return s;
  endfunction

  assign disp_sz_in = clamp_size(disp_size);
  assign imm_sz_in  = clamp_size(imm_size);
  assign in_field   = (state == C_DISP) || (state == C_IMM);
  assign cur_size   = (state == C_IMM) ? imm_sz_q : disp_sz_q;
  assign cnt_inc    = cnt + 1'b1;
  assign last_byte  = (cnt_inc == cur_size);
  assign merge_acc  = (state == C_IMM) ? imm_acc : disp_acc;

  const_byte_merge #(.OUT_W(OUT_W), .IDX_W(SZ_W)) u_merge (
    .acc     (merge_acc),
    .byte_in (byte_data),
    .idx     (cnt),
    .zext    (zext_q),
    .merged  (merged)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= C_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = C_IDLE;
    end else begin
      case (state)
        C_IDLE: if (start) begin
          if (disp_sz_in != '0)     state_next = C_DISP;
          else if (imm_sz_in != '0) state_next = C_IMM;
          else                      state_next = C_OUT;
        end
        C_DISP: if (byte_valid && last_byte)
          state_next = (imm_sz_q != '0) ? C_IMM : C_OUT;
        C_IMM:  if (byte_valid && last_byte) state_next = C_OUT;
        C_OUT:  if (out_ready) state_next = C_IDLE;
        default: state_next = C_IDLE;
      endcase
    end
  end

  // Handshake and status outputs, decoded from the state register only.
  always_comb begin
    start_ready = 1'b0;
    byte_ready  = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (state)
      C_IDLE: begin start_ready = 1'b1; busy = 1'b0; end
      C_DISP, C_IMM: byte_ready = 1'b1;
      C_OUT:  out_valid = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  // Datapath: latch the request at start, fold each accepted byte into the
  // active field's accumulator. Accumulators are left alone on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_sz_q <= '0;
      imm_sz_q  <= '0;
      cnt       <= '0;
      disp_acc  <= '0;
      imm_acc   <= '0;
      to_q      <= '0;
`ifdef FETCH_CONST_ZEXT_EN
      zext_q    <= 1'b0;
`endif
    end else if (flush) begin
      cnt <= '0;
    end else if (state == C_IDLE && start) begin
      disp_sz_q <= disp_sz_in;
      imm_sz_q  <= imm_sz_in;
      to_q      <= to_mask;
      cnt       <= '0;
      disp_acc  <= '0;
      imm_acc   <= '0;
`ifdef FETCH_CONST_ZEXT_EN
      zext_q    <= zext;
`endif
    end else if (in_field && byte_valid) begin
      if (state == C_DISP) disp_acc <= merged;
      else                 imm_acc  <= merged;
      cnt <= last_byte ? '0 : cnt_inc;
    end
  end

  assign out_disp = disp_acc;
  assign out_imm  = imm_acc;
  assign out_to   = to_q;

endmodule

// File: tb/tb_fetch_const_assembler.sv
// Directed bench for fetch_const_assembler: a table of field-pair vectors
// with hand-computed constants, plus hand-written sequences for hold,
// byte_valid gaps, flush and asynchronous reset.
module tb_fetch_const_assembler;

  localparam int OUT_W = 64;
  localparam int MQ_N  = 4;
  localparam int SZ_W  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             start_ready;
  logic [SZ_W-1:0]  disp_size, imm_size;
  logic [MQ_N-1:0]  to_mask;
`ifdef FETCH_CONST_ZEXT_EN
  logic             zext;
`endif
  logic             flush;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_disp, out_imm;
  logic [MQ_N-1:0]  out_to;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_const_assembler #(.MAX_BYTES(8), .OUT_W(OUT_W), .MQ_N(MQ_N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_ready (start_ready),
    .disp_size   (disp_size),
    .imm_size    (imm_size),
    .to_mask     (to_mask),
`ifdef FETCH_CONST_ZEXT_EN
    .zext        (zext),
`endif
    .flush       (flush),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_disp    (out_disp),
    .out_imm     (out_imm),
    .out_to      (out_to),
    .busy        (busy)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [SZ_W-1:0]  dsz;
    logic [SZ_W-1:0]  isz;
    logic [MQ_N-1:0]  to;
    int               nbytes;     // bytes actually consumed (after clamp)
    logic [127:0]     bytes;      // stream, first byte in bits [7:0]
    logic [OUT_W-1:0] exp_disp;
    logic [OUT_W-1:0] exp_imm;
    int               hold;       // cycles out_ready stays low while valid
  } vec_t;

  vec_t vecs[7];

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [OUT_W-1:0] act,
                     input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [OUT_W-1:0] ed, ei;
    start     = 1'b1;
    disp_size = v.dsz;
    imm_size  = v.isz;
    to_mask   = v.to;
    step();
    start     = 1'b0;
    disp_size = '0;       // prove the sizes were latched
    imm_size  = '0;
    to_mask   = '0;
    if (v.nbytes > 0) chk({tag, " byte_ready after start"}, 64'(byte_ready), 64'd1);
    for (int k = 0; k < v.nbytes; k++) begin
      byte_valid = 1'b1;
      byte_data  = v.bytes[8*k +: 8];
      step();
    end
    byte_valid = 1'b0;
    exp_q.push_back(v.exp_disp);
    exp_q.push_back(v.exp_imm);
    ed = exp_q.pop_front();
    ei = exp_q.pop_front();
    chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, " out_disp"}, out_disp, ed);
    chk({tag, " out_imm"}, out_imm, ei);
    chk({tag, " out_to"}, 64'(out_to), 64'(v.to));
    for (int h = 0; h < v.hold; h++) begin
      step();
      chk({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
      chk({tag, " hold out_disp"}, out_disp, ed);
      chk({tag, " hold out_imm"}, out_imm, ei);
      chk({tag, " hold out_to"}, 64'(out_to), 64'(v.to));
    end
    out_ready = 1'b1;
    start     = 1'b1;     // must not be taken in the accepting cycle
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    chk({tag, " start_ready after accept"}, 64'(start_ready), 64'd1);
    chk({tag, " busy after accept"}, 64'(busy), 64'd0);
    chk({tag, " out_valid after accept"}, 64'(out_valid), 64'd0);
  endtask

  // Enter C_IMM of a 1/2 field pair with one immediate byte already taken.
  task automatic enter_imm();
    start = 1'b1; disp_size = 4'd1; imm_size = 4'd2; to_mask = 4'b0011;
    step();
    start = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h11; step();
    byte_valid = 1'b1; byte_data = 8'h22; step();
    byte_valid = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t v11;

  initial begin
    vecs[0] = '{4'd1, 4'd0, 4'b0001, 1, 128'hF0,
                64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 0};
    vecs[1] = '{4'd4, 4'd2, 4'b0101, 6, 128'hF234_1234_5678,
                64'h0000_0000_1234_5678, 64'hFFFF_FFFF_FFFF_F234, 5};
    vecs[2] = '{4'd8, 4'd8, 4'b1111, 16,
                128'hF122_3344_5566_7788_0807_0605_0403_0201,
                64'h0807_0605_0403_0201, 64'hF122_3344_5566_7788, 0};
    vecs[3] = '{4'd2, 4'd1, 4'b1000, 3, 128'h7F_8000,
                64'hFFFF_FFFF_FFFF_8000, 64'h0000_0000_0000_007F, 1};
    vecs[4] = '{4'd15, 4'd0, 4'b0010, 8, 128'h0877_6655_4433_2211,
                64'h0877_6655_4433_2211, 64'h0, 0};
    vecs[5] = '{4'd0, 4'd4, 4'b0100, 4, 128'h7FFF_FFFF,
                64'h0, 64'h0000_0000_7FFF_FFFF, 0};
    vecs[6] = '{4'd0, 4'd0, 4'b1001, 0, 128'h0,
                64'h0, 64'h0, 2};
    v11     = '{4'd1, 4'd1, 4'b0110, 2, 128'h85_05,
                64'h0000_0000_0000_0005, 64'hFFFF_FFFF_FFFF_FF85, 0};

    rst = 1'b1; start = 1'b0; disp_size = '0; imm_size = '0; to_mask = '0;
    flush = 1'b0; byte_valid = 1'b0; byte_data = '0; out_ready = 1'b0;
`ifdef FETCH_CONST_ZEXT_EN
    zext = 1'b0;
`endif
    #12;
    chk("reset start_ready", 64'(start_ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset byte_ready", 64'(byte_ready), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_disp", out_disp, 64'd0);
    chk("reset out_imm", out_imm, 64'd0);
    chk("reset out_to", 64'(out_to), 64'd0);
    @(negedge clk); rst = 1'b0;
    step();

    // Bytes offered while idle are ignored.
    byte_valid = 1'b1; byte_data = 8'hAA;
    step();
    byte_valid = 1'b0;
    chk("idle byte busy", 64'(busy), 64'd0);
    chk("idle byte_ready", 64'(byte_ready), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // byte_valid gaps: 1,0,1,0 with disp_size=2.
    start = 1'b1; disp_size = 4'd2; imm_size = 4'd0; to_mask = 4'b0001;
    step();
    start = 1'b0;
    byte_valid = 1'b1; byte_data = 8'hAB; step();
    byte_valid = 1'b0; byte_data = 8'hEE; step();
    chk("gap out_valid mid", 64'(out_valid), 64'd0);
    chk("gap byte_ready mid", 64'(byte_ready), 64'd1);
    byte_valid = 1'b1; byte_data = 8'h12; step();
    byte_valid = 1'b0; byte_data = 8'hEE;
    chk("gap out_valid", 64'(out_valid), 64'd1);
    chk("gap out_disp", out_disp, 64'h0000_0000_0000_12AB);
    step();
    chk("gap out_disp held", out_disp, 64'h0000_0000_0000_12AB);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("gap start_ready", 64'(start_ready), 64'd1);

    // flush mid-C_IMM, with a byte offered in the same cycle.
    enter_imm();
    chk("pre-flush byte_ready", 64'(byte_ready), 64'd1);
    flush = 1'b1; byte_valid = 1'b1; byte_data = 8'h33;
    step();
    flush = 1'b0; byte_valid = 1'b0;
    chk("flush start_ready", 64'(start_ready), 64'd1);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    step();
    chk("flush out_valid later", 64'(out_valid), 64'd0);
    run_vec(v11, "after_flush");

    // flush beats start in the same cycle.
    flush = 1'b1; start = 1'b1; disp_size = 4'd1;
    step();
    flush = 1'b0; start = 1'b0; disp_size = '0;
    chk("flush+start busy", 64'(busy), 64'd0);

    // Asynchronous reset mid-C_IMM.
    enter_imm();
    #2 rst = 1'b1;
    #1;
    chk("rst async start_ready", 64'(start_ready), 64'd1);
    chk("rst async out_valid", 64'(out_valid), 64'd0);
    chk("rst async out_imm", out_imm, 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("rst out_valid later", 64'(out_valid), 64'd0);
    run_vec(v11, "after_rst");

`ifdef FETCH_CONST_ZEXT_EN
    begin
      vec_t vz;
      vz = '{4'd0, 4'd1, 4'b0001, 1, 128'h80, 64'h0, 64'h80, 0};
      zext = 1'b1;
      run_vec(vz, "zext");
      zext = 1'b0;
    end
`endif

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the sequence above is ever broken.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary expected summary");
    $fatal(1);
  end

endmodule
